// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - pipeline sequencer: stall/flush/enable control for the 5-stage core
// Holds RUN/MULT/HALT state and a multiply-latency counter; every output is decoded from them and the inputs.
module hazard_controller #(
   parameter int MULT_LATENCY = 4,
   parameter int CNT_W        = 3
) (
   input  logic       CLK,
   input  logic       nRST,
   input  logic       ihit,
   input  logic       dhit,
   input  logic       mem_dreq,
   input  logic       ex_mult,
   input  logic       ex_dread,
   input  logic [4:0] ex_rd,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       mispredict,
   input  logic       wb_halt,
   output logic       pc_en,
   output logic       fd_en,
   output logic       fd_flush,
   output logic       de_en,
   output logic       de_flush,
   output logic       em_en,
   output logic       em_flush,
   output logic       mw_en,
   output logic       mult_start,
   output logic       halted
);

   typedef enum logic [1:0] {S_RUN, S_MULT, S_HALT} state_t;

   localparam bit             MULT_STALLS = (MULT_LATENCY > 1);
   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(MULT_STALLS ? MULT_LATENCY - 2 : 0);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             memstall;
   logic             loaduse;

   assign memstall = mem_dreq & ~dhit;
   assign loaduse  = ex_dread & (ex_rd != 5'd0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= S_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pc_en      = 1'b1;
      fd_en      = 1'b1;
      fd_flush   = 1'b0;
      de_en      = 1'b1;
      de_flush   = 1'b0;
      em_en      = 1'b1;
      em_flush   = 1'b0;
      mw_en      = 1'b1;
      mult_start = 1'b0;
      halted     = 1'b0;

      unique case (state_q)
         S_RUN: begin
            if (wb_halt) begin
               {pc_en, fd_en, de_en, em_en, mw_en} = '0;
               state_d = S_HALT;
            end else if (memstall) begin
               {pc_en, fd_en, de_en, em_en, mw_en} = '0;
            end else if (ex_mult && MULT_STALLS) begin
               // multiply occupies EX: freeze the front end and feed a bubble into MEM
               mult_start = 1'b1;
               pc_en      = 1'b0;
               fd_en      = 1'b0;
               de_en      = 1'b0;
               em_flush   = 1'b1;
               cnt_d      = CNT_LOAD;
               state_d    = S_MULT;
            end else if (ex_mult) begin
               mult_start = 1'b1;
            end else if (mispredict) begin
               fd_flush = 1'b1;
               de_flush = 1'b1;
            end else if (loaduse) begin
               pc_en    = 1'b0;
               fd_en    = 1'b0;
               de_flush = 1'b1;
            end else if (!ihit) begin
               pc_en    = 1'b0;
               fd_flush = 1'b1;
            end
         end

         S_MULT: begin
            // counter keeps running through memory stalls so only the release can be delayed
            cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_ONE;
            if (wb_halt) begin
               {pc_en, fd_en, de_en, em_en, mw_en} = '0;
               state_d = S_HALT;
            end else if ((cnt_q == '0) && !memstall) begin
               state_d = S_RUN;
            end else if (memstall) begin
               {pc_en, fd_en, de_en, em_en, mw_en} = '0;
            end else begin
               pc_en    = 1'b0;
               fd_en    = 1'b0;
               de_en    = 1'b0;
               em_flush = 1'b1;
            end
         end

         S_HALT: begin
            {pc_en, fd_en, de_en, em_en, mw_en} = '0;
            halted = 1'b1;
         end

         default: begin
            state_d = S_RUN;
         end
      endcase
   end

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - table-driven scoreboard bench for hazard_controller
module tb_hazard_controller;

   logic       CLK = 1'b0;
   logic       nRST;
   logic       ihit, dhit, mem_dreq, ex_mult, ex_dread, mispredict, wb_halt;
   logic [4:0] ex_rd, id_rs1, id_rs2;
   logic       pc_en, fd_en, fd_flush, de_en, de_flush, em_en, em_flush, mw_en, mult_start, halted;

   hazard_controller #(.MULT_LATENCY(4), .CNT_W(3)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dreq(mem_dreq),
      .ex_mult(ex_mult), .ex_dread(ex_dread), .ex_rd(ex_rd), .id_rs1(id_rs1),
      .id_rs2(id_rs2), .mispredict(mispredict), .wb_halt(wb_halt),
      .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush), .de_en(de_en),
      .de_flush(de_flush), .em_en(em_en), .em_flush(em_flush), .mw_en(mw_en),
      .mult_start(mult_start), .halted(halted)
   );

   always #5 CLK = ~CLK;

   // {pc_en fd_en fd_flush de_en de_flush em_en em_flush mw_en mult_start halted}
   localparam logic [9:0] O_ADV   = 10'b11_0101_0100;
   localparam logic [9:0] O_NONE  = 10'b00_0000_0000;
   localparam logic [9:0] O_LDUSE = 10'b00_0111_0100;
   localparam logic [9:0] O_MISP  = 10'b11_1111_0100;
   localparam logic [9:0] O_IMISS = 10'b01_1101_0100;
   localparam logic [9:0] O_MSTRT = 10'b00_0001_1110;
   localparam logic [9:0] O_MHOLD = 10'b00_0001_1100;
   localparam logic [9:0] O_HALTD = 10'b00_0000_0001;

   typedef struct {
      logic       ihit, dhit, mreq, mult, dread;
      logic [4:0] rd, rs1, rs2;
      logic       misp, halt;
      logic [9:0] exp;
      string      name;
   } vec_t;

   logic [9:0] outs;
   assign outs = {pc_en, fd_en, fd_flush, de_en, de_flush, em_en, em_flush, mw_en, mult_start, halted};

   logic [9:0] exp_q[$];
   string      name_q[$];
   int         n_vec = 0;
   int         n_bad = 0;
   vec_t       tbl[12];

   function automatic vec_t mk(logic ih, logic dh, logic mr, logic mu, logic dr,
                               logic [4:0] rd, logic [4:0] r1, logic [4:0] r2,
                               logic mp, logic hl, logic [9:0] e, string n);
      vec_t v;
      v.ihit = ih; v.dhit = dh; v.mreq = mr; v.mult = mu; v.dread = dr;
      v.rd = rd; v.rs1 = r1; v.rs2 = r2; v.misp = mp; v.halt = hl;
      v.exp = e; v.name = n;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      ihit = v.ihit; dhit = v.dhit; mem_dreq = v.mreq; ex_mult = v.mult;
      ex_dread = v.dread; ex_rd = v.rd; id_rs1 = v.rs1; id_rs2 = v.rs2;
      mispredict = v.misp; wb_halt = v.halt;
      exp_q.push_back(v.exp);
      name_q.push_back(v.name);
   endtask

   task automatic check_now();
      logic [9:0] e;
      string      n;
      n_vec++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $display("FAIL scoreboard_empty got=%b", outs);
      end else begin
         e = exp_q.pop_front();
         n = name_q.pop_front();
         if (outs !== e) begin
            n_bad++;
            $display("FAIL %s got=%b exp=%b", n, outs, e);
         end
      end
   endtask

   // drive after the edge, compare on the falling edge, then step past the next rising edge
   task automatic apply(input vec_t v);
      drive(v);
      @(negedge CLK);
      check_now();
      @(posedge CLK);
      #1;
   endtask

   function automatic vec_t idle(logic [9:0] e, string n);
      return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, e, n);
   endfunction

   function automatic vec_t mul(logic mr, logic dh, logic [9:0] e, string n);
      return mk(1, dh, mr, 1, 0, 0, 0, 0, 0, 0, e, n);
   endfunction

   initial begin
      tbl[0]  = mk(1,0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, O_ADV,   "idle");
      tbl[1]  = mk(1,0,0,0,1, 5'd5, 5'd1, 5'd5, 0,0, O_LDUSE, "loaduse_rs2");
      tbl[2]  = mk(1,0,0,0,1, 5'd9, 5'd9, 5'd3, 0,0, O_LDUSE, "loaduse_rs1");
      tbl[3]  = mk(1,0,0,0,1, 5'd0, 5'd0, 5'd0, 0,0, O_ADV,   "loaduse_rd0");
      tbl[4]  = mk(1,0,0,0,1, 5'd7, 5'd6, 5'd8, 0,0, O_ADV,   "load_nomatch");
      tbl[5]  = mk(1,0,0,0,0, 5'd5, 5'd5, 5'd5, 0,0, O_ADV,   "match_not_load");
      tbl[6]  = mk(1,0,0,0,1, 5'd5, 5'd5, 5'd5, 1,0, O_MISP,  "misp_over_loaduse");
      tbl[7]  = mk(0,0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, O_IMISS, "imiss");
      tbl[8]  = mk(0,0,0,0,1, 5'd4, 5'd4, 5'd0, 0,0, O_LDUSE, "loaduse_over_imiss");
      tbl[9]  = mk(1,0,1,0,0, 5'd0, 5'd0, 5'd0, 0,0, O_NONE,  "memstall");
      tbl[10] = mk(1,1,1,0,0, 5'd0, 5'd0, 5'd0, 0,0, O_ADV,   "mem_hit");
      tbl[11] = mk(0,0,1,0,1, 5'd3, 5'd3, 5'd3, 1,0, O_NONE,  "memstall_over_misp");

      nRST = 1'b0;
      drive(idle(O_ADV, "in_reset"));
      #3;
      check_now();
      @(negedge CLK);
      nRST = 1'b1;
      @(posedge CLK);
      #1;

      for (int i = 0; i < 12; i++) apply(tbl[i]);

      // multiply with no memory stalls: held three cycles, released on the fourth
      apply(mul(0, 0, O_MSTRT, "mult_c0"));
      apply(mul(0, 0, O_MHOLD, "mult_c1"));
      apply(mul(0, 0, O_MHOLD, "mult_c2"));
      apply(mul(0, 0, O_ADV,   "mult_c3_release"));
      apply(mul(0, 0, O_MSTRT, "mult_back_in_run"));
      apply(mul(1, 0, O_NONE,  "mult2_stall_c1"));
      apply(mul(0, 0, O_MHOLD, "mult2_c2"));
      apply(mul(1, 0, O_NONE,  "mult2_stall_c3"));
      apply(mul(1, 0, O_NONE,  "mult2_stall_c4"));
      apply(mul(1, 0, O_NONE,  "mult2_stall_c5"));
      apply(mul(1, 1, O_ADV,   "mult2_release_dhit"));
      apply(idle(O_ADV, "after_mult2"));

      // asynchronous reset in the middle of a multiply hold
      apply(mul(0, 0, O_MSTRT, "mult3_c0"));
      apply(mul(0, 0, O_MHOLD, "mult3_c1"));
      drive(idle(O_ADV, "async_reset"));
      #2;
      nRST = 1'b0;
      #1;
      check_now();
      @(negedge CLK);
      nRST = 1'b1;
      @(posedge CLK);
      #1;
      apply(idle(O_ADV, "after_async_reset"));

      // halt latches until reset regardless of later inputs
      apply(mk(1,0,0,0,0, 0,0,0, 0,1, O_NONE, "halt_cycle"));
      apply(mul(0, 0, O_HALTD, "halted_mult"));
      apply(mk(0,0,0,0,0, 0,0,0, 1,0, O_HALTD, "halted_imiss"));
      apply(idle(O_HALTD, "halted_idle"));
      drive(idle(O_ADV, "halt_reset"));
      #2;
      nRST = 1'b0;
      #1;
      check_now();
      @(negedge CLK);
      nRST = 1'b1;
      @(posedge CLK);
      #1;

      // halt arriving during a multiply hold
      apply(mul(0, 0, O_MSTRT, "mult4_c0"));
      apply(mk(1,0,0,1,0, 0,0,0, 0,1, O_NONE, "mult4_halt"));
      apply(mul(0, 0, O_HALTD, "mult4_halted"));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
